// File: rtl/rdata_return_buffer.sv
// rdata_return_buffer
//
// Read-data return buffer for the bank-level controller. The scheduler claims
// one slot for each READ it issues. Read data coming back from the DRAM cannot
// be stalled, and it is written into a claimed slot. The frontend drains the
// entries in arrival order through a valid/ready handshake. Each claimed slot
// is one credit, so a beat that arrives against a claimed slot always has
// space.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   rsv_req             scheduler claims one slot this cycle
//   can_reserve         at least one unclaimed slot exists (registered decode)
//   dram_rvalid/rdata/rid  read-data beat from the DRAM; it cannot be stalled
//   rd_valid/rd_data/rd_id  head entry presented to the frontend
//   rd_ready            frontend accepts the head entry
//   count               number of stored entries, 0..DEPTH
//   outstanding         claimed slots still waiting for data, 0..DEPTH
//   err_status          sticky flags: [0] data arrived with no claimed slot,
//                       [1] a claim was refused
module rdata_return_buffer #(
  parameter int RDATA_WIDTH = 128,
  parameter int ID_WIDTH    = 4,
  parameter int DEPTH       = 16,
  parameter int PTR_WIDTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rsv_req,
  output logic                   can_reserve,
  input  logic                   dram_rvalid,
  input  logic [RDATA_WIDTH-1:0] dram_rdata,
  input  logic [ID_WIDTH-1:0]    dram_rid,
  output logic                   rd_valid,
  output logic [RDATA_WIDTH-1:0] rd_data,
  output logic [ID_WIDTH-1:0]    rd_id,
  input  logic                   rd_ready,
  output logic [PTR_WIDTH:0]     count,
  output logic [PTR_WIDTH:0]     outstanding,
  output logic [1:0]             err_status
);

  localparam int ENTRY_W = ID_WIDTH + RDATA_WIDTH;
  localparam logic [PTR_WIDTH-1:0] PTR_ONE = 1;
  localparam logic [PTR_WIDTH:0]   CNT_ONE = 1;

  logic [ENTRY_W-1:0]   mem [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic [PTR_WIDTH+1:0] claimed;
  logic                 rsv_ok;
  logic                 arr_ok;
  logic                 pop;
  logic [PTR_WIDTH:0]   count_nxt;
  logic [PTR_WIDTH:0]   outstanding_nxt;

  // Status outputs decode registered state only, so there is no combinational
  // path from any input to them.
  assign claimed     = {1'b0, count} + {1'b0, outstanding};
  assign can_reserve = claimed < (PTR_WIDTH + 2)'(DEPTH);
  assign rd_valid    = (count != '0);
  assign {rd_id, rd_data} = mem[rd_ptr];

  assign rsv_ok = rsv_req && can_reserve;
  // A beat with no claimed slot is dropped. This also covers a full buffer,
  // because count == DEPTH forces outstanding == 0.
  assign arr_ok = dram_rvalid && (outstanding != '0);
  assign pop    = rd_valid && rd_ready;

  // Net deltas, so any combination of claim, arrival and pop in one cycle
  // sustains full throughput.
  always_comb begin
    count_nxt       = count;
    outstanding_nxt = outstanding;
    if (arr_ok && !pop) begin
      count_nxt = count + CNT_ONE;
    end else if (!arr_ok && pop) begin
      count_nxt = count - CNT_ONE;
    end
    if (rsv_ok && !arr_ok) begin
      outstanding_nxt = outstanding + CNT_ONE;
    end else if (!rsv_ok && arr_ok) begin
      outstanding_nxt = outstanding - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      err_status  <= 2'b00;
    end else begin
      count       <= count_nxt;
      outstanding <= outstanding_nxt;
      if (arr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)    rd_ptr <= rd_ptr + PTR_ONE;
      if (dram_rvalid && !arr_ok) err_status[0] <= 1'b1;
      if (rsv_req && !can_reserve) err_status[1] <= 1'b1;
    end
  end

  // Storage is cleared on reset so that rd_data/rd_id read as zero afterwards.
  // When count < DEPTH, the write at wr_ptr never aliases the head entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (arr_ok) begin
      mem[wr_ptr] <= {dram_rid, dram_rdata};
    end
  end

endmodule

// File: tb/tb_rdata_return_buffer.sv
module tb_rdata_return_buffer;

  localparam int RW = 128;
  localparam int IW = 4;
  localparam int DP = 16;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          rsv_req;
  logic          can_reserve;
  logic          dram_rvalid;
  logic [RW-1:0] dram_rdata;
  logic [IW-1:0] dram_rid;
  logic          rd_valid;
  logic [RW-1:0] rd_data;
  logic [IW-1:0] rd_id;
  logic          rd_ready;
  logic [PW:0]   count;
  logic [PW:0]   outstanding;
  logic [1:0]    err_status;

  rdata_return_buffer #(
    .RDATA_WIDTH(RW), .ID_WIDTH(IW), .DEPTH(DP), .PTR_WIDTH(PW)
  ) dut (
    .clk(clk), .rst(rst),
    .rsv_req(rsv_req), .can_reserve(can_reserve),
    .dram_rvalid(dram_rvalid), .dram_rdata(dram_rdata), .dram_rid(dram_rid),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_id(rd_id), .rd_ready(rd_ready),
    .count(count), .outstanding(outstanding), .err_status(err_status)
  );

  always #5 clk = ~clk;

  // Reference model: an ordered queue of stored beats, a credit counter and
  // the sticky error bits.
  logic [IW+RW-1:0] q[$];
  int               m_outst;
  logic [1:0]       m_err;
  int               n_chk;
  int               n_fail;

  task automatic chk_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [IW+RW-1:0] head;
    chk_val("count", 256'(count), 256'(q.size()));
    chk_val("outstanding", 256'(outstanding), 256'(m_outst));
    chk_val("rd_valid", 256'(rd_valid), 256'(q.size() != 0));
    chk_val("can_reserve", 256'(can_reserve), 256'((q.size() + m_outst) < DP));
    chk_val("err_status", 256'(err_status), 256'(m_err));
    if (q.size() != 0) begin
      head = q[0];
      chk_val("rd_data", 256'(rd_data), 256'(head[RW-1:0]));
      chk_val("rd_id", 256'(rd_id), 256'(head[IW+RW-1:RW]));
    end
  endtask

  // One clock cycle: drive inputs, advance the model, check after the edge.
  task automatic step(input logic rsv, input logic dv, input logic [RW-1:0] d,
                      input logic [IW-1:0] id, input logic rdy);
    bit can;
    rsv_req     = rsv;
    dram_rvalid = dv;
    dram_rdata  = d;
    dram_rid    = id;
    rd_ready    = rdy;
    can = (q.size() + m_outst) < DP;
    if (rdy && q.size() != 0) q.delete(0);
    if (dv) begin
      if (m_outst != 0) begin
        q.push_back({id, d});
        m_outst--;
      end else begin
        m_err[0] = 1'b1;
      end
    end
    if (rsv) begin
      if (can) m_outst++;
      else m_err[1] = 1'b1;
    end
    @(posedge clk);
    #1;
    check_outputs();
    rsv_req     = 1'b0;
    dram_rvalid = 1'b0;
    rd_ready    = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    m_outst = 0;
    m_err   = 2'b00;
    check_outputs();
    chk_val("rst_rd_data", 256'(rd_data), 256'(0));
    chk_val("rst_rd_id", 256'(rd_id), 256'(0));
  endtask

  function automatic logic [RW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [RW-1:0] d;
    int pr_rsv, pr_dv, pr_rdy;
    n_chk = 0; n_fail = 0;
    rst = 1'b1; rsv_req = 1'b0; dram_rvalid = 1'b0; rd_ready = 1'b0;
    dram_rdata = '0; dram_rid = '0;
    q.delete(); m_outst = 0; m_err = 2'b00;
    @(posedge clk);
    #1;
    do_reset();

    // Basic flow
    step(1, 0, '0, '0, 0);
    step(0, 1, RW'(16'hA5A5), 4'd3, 0);
    chk_val("basic_data", 256'(rd_data), 256'(16'hA5A5));
    chk_val("basic_id", 256'(rd_id), 256'(3));
    step(0, 0, '0, '0, 1);
    chk_val("basic_drained", 256'(rd_valid), 256'(0));

    // Credit exhaustion
    for (int i = 0; i < DP; i++) step(1, 0, '0, '0, 0);
    chk_val("exhaust_can", 256'(can_reserve), 256'(0));
    step(1, 0, '0, '0, 0);
    chk_val("exhaust_outst", 256'(outstanding), 256'(16));
    chk_val("exhaust_err1", 256'(err_status[1]), 256'(1));

    // Fill and wrap, three passes
    do_reset();
    step(0, 0, '0, '0, 1);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < DP; i++) begin
        step(1, 0, '0, '0, 0);
        step(0, 1, RW'(i), IW'(i), 0);
      end
      chk_val("fill_count", 256'(count), 256'(16));
      chk_val("fill_can", 256'(can_reserve), 256'(0));
      for (int i = 0; i < DP; i++) begin
        chk_val("drain_order", 256'(rd_data), 256'(i));
        step(0, 0, '0, '0, 1);
      end
    end

    // Concurrent claim + arrival + pop at count=5, outstanding=3
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 0, '0, '0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, RW'(100 + i), IW'(i), 0);
    step(1, 1, RW'(200), 4'hF, 1);
    chk_val("conc_count", 256'(count), 256'(5));
    chk_val("conc_outst", 256'(outstanding), 256'(3));
    chk_val("conc_head", 256'(rd_data), 256'(101));

    // Unexpected data
    do_reset();
    step(0, 1, RW'(77), 4'd1, 0);
    chk_val("unexp_err0", 256'(err_status[0]), 256'(1));
    for (int i = 0; i < 4; i++) step(1, 0, '0, '0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, rnd_data(), IW'(i), 1);
    chk_val("unexp_sticky", 256'(err_status[0]), 256'(1));

    // Reset mid-stream at count=4, outstanding=2
    do_reset();
    for (int i = 0; i < 6; i++) step(1, 0, '0, '0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, RW'(300 + i), IW'(i), 0);
    do_reset();
    step(1, 0, '0, '0, 0);
    step(0, 1, RW'(999), 4'd9, 0);
    chk_val("post_rst_data", 256'(rd_data), 256'(999));

    // Randomized traffic with shifting probabilities
    do_reset();
    for (int ph = 0; ph < 8; ph++) begin
      pr_rsv = $urandom_range(20, 90);
      pr_dv  = $urandom_range(20, 90);
      pr_rdy = $urandom_range(10, 95);
      for (int c = 0; c < 300; c++) begin
        d = rnd_data();
        if ($urandom_range(0, 999) == 0) do_reset();
        step(($urandom_range(0, 99) < pr_rsv), ($urandom_range(0, 99) < pr_dv),
             d, IW'($urandom), ($urandom_range(0, 99) < pr_rdy));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
